// File: rtl/passcode_responder.sv
// Passcode check engine: stores a 1-4 digit system code, buffers entered digits,
// compares on request, counts consecutive failures and runs a timed lockout sleep.
module passcode_responder #(
    parameter int SLEEP_CYCLES = 250000000,
    parameter int MAX_FAILS    = 3
) (
    input  logic       clk,
    input  logic       system_reset_n,
    input  logic       store_value,
    input  logic       input_value,
    input  logic       compare,
    input  logic       sleep,
    input  logic [3:0] digit,
    input  logic [1:0] pass_len,
    output logic       correct_password,
    output logic       invalid_password,
    output logic       end_sleep,
    output logic       lockout,
    output logic [1:0] fail_count,
    output logic [2:0] entry_count,
    output logic       busy
);
    localparam int              CW   = $clog2(SLEEP_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(SLEEP_CYCLES - 1);
    localparam logic [1:0]      MAXF = 2'(MAX_FAILS);

    typedef enum logic [1:0] {IDLE, CHECK, SLEEP, WAKE} state_t;
    state_t state, state_nx;

    logic [3:0]    sys [4];
    logic [3:0]    ebuf [4];
    logic [1:0]    sys_ptr;
    logic [1:0]    len_q;
    logic          ovf;
    logic          sleep_pend;
    logic [CW-1:0] cnt;
    logic          match;
    logic          acc_store, acc_input, acc_cmp, enter_sleep, result, wake;

    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) state <= IDLE;
        else                 state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        acc_store   = 1'b0;
        acc_input   = 1'b0;
        acc_cmp     = 1'b0;
        enter_sleep = 1'b0;
        result      = 1'b0;
        wake        = 1'b0;
        case (state)
            IDLE: begin
                // a sleep request latched during CHECK outranks any new strobe
                if (sleep || sleep_pend) begin
                    state_nx    = SLEEP;
                    enter_sleep = 1'b1;
                end else if (compare) begin
                    state_nx = CHECK;
                    acc_cmp  = 1'b1;
                end else if (input_value) begin
                    acc_input = 1'b1;
                end else if (store_value) begin
                    acc_store = 1'b1;
                end
            end
            CHECK: begin
                state_nx = IDLE;
                result   = 1'b1;
            end
            SLEEP: begin
                if (!sleep) begin
                    state_nx = IDLE;
                end else if (cnt == LAST) begin
                    state_nx = WAKE;
                    wake     = 1'b1;
                end
            end
            WAKE: if (!sleep) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        match = (entry_count == ({1'b0, len_q} + 3'd1)) && !ovf;
        for (int i = 0; i < 4; i++)
            if ((2'(i) <= len_q) && (ebuf[i] != sys[i])) match = 1'b0;
    end

    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            for (int i = 0; i < 4; i++) begin
                sys[i]  <= 4'd0;
                ebuf[i] <= 4'd0;
            end
            sys_ptr          <= 2'd0;
            len_q            <= 2'd0;
            ovf              <= 1'b0;
            sleep_pend       <= 1'b0;
            cnt              <= '0;
            entry_count      <= 3'd0;
            fail_count       <= 2'd0;
            correct_password <= 1'b0;
            invalid_password <= 1'b0;
            end_sleep        <= 1'b0;
        end else begin
            correct_password <= 1'b0;
            invalid_password <= 1'b0;
            end_sleep        <= 1'b0;
            if (acc_store) begin
                sys[sys_ptr] <= digit;
                sys_ptr      <= (sys_ptr >= pass_len) ? 2'd0 : sys_ptr + 2'd1;
            end
            if (acc_input) begin
                if (entry_count < 3'd4) begin
                    ebuf[entry_count[1:0]] <= digit;
                    entry_count            <= entry_count + 3'd1;
                end else begin
                    ovf <= 1'b1;
                end
            end
            if (acc_cmp) len_q <= pass_len;
            if (result) begin
                correct_password <= match;
                invalid_password <= !match;
                entry_count      <= 3'd0;
                ovf              <= 1'b0;
                if (match)                   fail_count <= 2'd0;
                else if (fail_count != MAXF) fail_count <= fail_count + 2'd1;
                if (sleep) sleep_pend <= 1'b1;
            end
            if (enter_sleep) begin
                cnt         <= '0;
                entry_count <= 3'd0;
                ovf         <= 1'b0;
                sleep_pend  <= 1'b0;
            end
            if (state == SLEEP && sleep && !wake) cnt <= cnt + CW'(1);
            if (wake) begin
                end_sleep  <= 1'b1;
                fail_count <= 2'd0;
            end
        end
    end

    assign lockout = (fail_count == MAXF);
    assign busy    = (state != IDLE);
endmodule

// File: doc/passcode_responder.md
PASSCODE_RESPONDER -- requirements
Module: passcode_responder

Interface
REQ-001 Parameter SLEEP_CYCLES, default 250000000, lockout duration in clk cycles (5 s at 50 MHz); legal range 2 or more.
REQ-002 Parameter MAX_FAILS, default 3, failed compares that assert lockout; legal range 1-3.
REQ-003 clk  in  1  single system clock, all state on rising edge.
REQ-004 system_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 store_value  in  1  one-cycle strobe from controller: write digit into system code.
REQ-006 input_value  in  1  one-cycle strobe from controller: write digit into entry buffer.
REQ-007 compare  in  1  one-cycle strobe from controller: check entry against system code.
REQ-008 sleep  in  1  level from controller: lockout period requested.
REQ-009 digit  in  4  digit value from switches, sampled on any accepted strobe.
REQ-010 pass_len  in  2  code length minus one (2'd3 = 4 digits), sampled on accepted compare and store_value.
REQ-011 correct_password  out  1  one-cycle pulse: compare matched.
REQ-012 invalid_password  out  1  one-cycle pulse: compare failed.
REQ-013 end_sleep  out  1  one-cycle pulse: lockout period elapsed.
REQ-014 lockout  out  1  level: fail_count equals MAX_FAILS.
REQ-015 fail_count  out  2  consecutive failed compares, saturating.
REQ-016 entry_count  out  3  digits held in entry buffer, 0-4.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, CHECK, SLEEP, WAKE; strobes are accepted only in IDLE and dropped in every other state.
REQ-019 Same-cycle strobe priority in IDLE: sleep > compare > input_value > store_value; lower-priority strobes in that cycle are dropped.
REQ-020 store_value: sys[sys_ptr] <= digit; sys_ptr increments and wraps to 0 after reaching pass_len.
REQ-021 input_value: when entry_count < 4, buf[entry_count] <= digit and entry_count increments; when entry_count = 4, digit is discarded and overflow flag sets.
REQ-022 compare: IDLE -> CHECK on the edge sampling compare; CHECK lasts exactly one cycle, then IDLE.
REQ-023 Match iff entry_count = pass_len+1, overflow clear, and buf[i] = sys[i] for all i <= pass_len.
REQ-024 Exactly one of correct_password and invalid_password pulses for exactly one cycle, on the cycle after CHECK (2 edges after the compare edge).
REQ-025 On that result edge, entry_count and overflow clear; match clears fail_count; mismatch increments fail_count, saturating at MAX_FAILS.
REQ-026 lockout is combinational from fail_count (fail_count = MAX_FAILS) and stays high until fail_count clears.
REQ-027 sleep high in IDLE: enter SLEEP, clear the cycle counter, clear entry buffer and overflow.
REQ-028 SLEEP: counter increments each cycle; when it reaches SLEEP_CYCLES-1, end_sleep pulses for one cycle, fail_count clears, and state goes to WAKE.
REQ-029 sleep dropping during SLEEP returns to IDLE with no end_sleep and fail_count unchanged.
REQ-030 WAKE: hold until sleep is low, then IDLE; end_sleep never pulses twice per sleep request.
REQ-031 sleep sampled high in CHECK is held: the result is issued first, then the next IDLE cycle enters SLEEP.
REQ-032 Counter is wide enough for SLEEP_CYCLES-1 and never wraps.

Reset
REQ-033 system_reset_n low asynchronously forces IDLE, sys[0..3] = 4'd0, sys_ptr = 0, entry_count = 0, overflow = 0, fail_count = 0, counter = 0, and all pulse outputs and busy low, including mid-CHECK or mid-SLEEP.
REQ-034 After reset release, the first strobe is accepted on the first rising edge.

Verification (SLEEP_CYCLES=8, MAX_FAILS=3 in bench)
REQ-035 Inputs: pass_len=3; store 1,2,3,4; input 1,2,3,4; compare -> correct_password high exactly 2 edges after compare; fail_count=0; entry_count=0.
REQ-036 Inputs: same stored code; input 1,2,3 and compare, then input 1,2,3,4,5 and compare, then input 9,9,9,9 and compare -> three invalid_password pulses; fail_count 1,2,3; lockout high after the third.
REQ-037 Inputs: lockout high, raise sleep -> busy high; end_sleep pulses once 8 cycles after entry; fail_count=0; hold sleep high 5 more cycles with no second pulse; drop sleep -> IDLE.
REQ-038 Inputs: sleep raised then dropped after 3 cycles -> no end_sleep; fail_count unchanged.
REQ-039 Inputs: compare and input_value in the same IDLE cycle -> digit discarded; result based on prior buffer; input_value during CHECK ignored.
REQ-040 Inputs: system_reset_n pulsed low mid-SLEEP and mid-CHECK -> all outputs 0 immediately; no result pulse; subsequent compare with 4 entered zeros and pass_len=3 -> correct_password.
